// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: byte/half/word accesses to a word-addressed memory, with sub-word
// stores done as read-modify-write. Optional macro MISALIGN_TRAP_EN traps misaligned half/word.
module load_store_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {StIdle, StAccess, StWrite, StResp} state_e;

  state_e      state_q, state_d;
  logic        write_q, signed_q, error_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q, buf_q, rdata_q;

  logic        is_byte, is_half, is_word, misalign, mem_write_raw;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_val, merged;

  assign is_byte = (size_q == 2'b00);
  assign is_half = (size_q == 2'b01);
  assign is_word = size_q[1];

`ifdef MISALIGN_TRAP_EN
  assign misalign = (is_half && addr_q[0]) || (is_word && (addr_q[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  // Without trapping, half/word simply use the aligned-down lane.
  assign byte_lane = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
  assign half_lane = mem_rdata[{addr_q[1], 4'b0000} +: 16];

  always_comb begin
    load_val = mem_rdata;
    if (is_byte) begin
      load_val = {{24{signed_q & byte_lane[7]}}, byte_lane};
    end else if (is_half) begin
      load_val = {{16{signed_q & half_lane[15]}}, half_lane};
    end
  end

  always_comb begin
    merged = buf_q;
    if (is_byte) begin
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end else begin
      merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end
  end

  always_comb begin
    state_d       = state_q;
    req_ready     = 1'b0;
    resp_valid    = 1'b0;
    mem_write_raw = 1'b0;
    mem_wdata     = 32'h0;
    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) state_d = StAccess;
      end
      StAccess: begin
        if (misalign || !write_q) begin
          state_d = StResp;
        end else if (is_word) begin
          mem_write_raw = 1'b1;
          mem_wdata     = wdata_q;
          state_d       = StResp;
        end else begin
          state_d = StWrite;
        end
      end
      StWrite: begin
        mem_write_raw = 1'b1;
        mem_wdata     = merged;
        state_d       = StResp;
      end
      StResp: begin
        resp_valid = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // A write must never reach memory while reset is held, even mid-transaction.
  assign mem_write   = mem_write_raw & ~reset;
  assign mem_address = {addr_q[31:2], 2'b00};
  assign resp_rdata  = rdata_q;
  assign resp_error  = error_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      write_q  <= 1'b0;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      buf_q    <= 32'h0;
      rdata_q  <= 32'h0;
      error_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && req_valid) begin
        write_q  <= req_write;
        size_q   <= req_size;
        signed_q <= req_signed;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
      end
      if (state_q == StAccess) begin
        if (write_q && !is_word) buf_q <= mem_rdata;
        rdata_q <= (write_q || misalign) ? 32'h0 : load_val;
        error_q <= misalign;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed, table-driven bench for load_store_unit with a small behavioural data memory.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_error, mem_write;
  logic [31:0] resp_rdata, mem_address, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_size    (req_size),
    .req_signed  (req_signed),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_error  (resp_error),
    .mem_write   (mem_write),
    .mem_address (mem_address),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  // Data memory: combinational read, clocked write; preload port used during reset.
  logic [31:0] mem [0:63];
  logic        preload;
  logic [5:0]  pl_idx;
  logic [31:0] pl_data;
  assign mem_rdata = mem[mem_address[7:2]];
  always @(posedge clk) begin
    if (preload) mem[pl_idx] <= pl_data;
    else if (mem_write) mem[mem_address[7:2]] <= mem_wdata;
  end

  int          wr_cnt = 0;
  logic [31:0] last_wd = 32'h0;
  always @(negedge clk) begin
    if (mem_write) begin
      wr_cnt  = wr_cnt + 1;
      last_wd = mem_wdata;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_wr;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs [12];

  task automatic run_vec(input int idx, input vec_t v);
    int lat;
    int wr0;
    string tag;
    tag = $sformatf("v%0d", idx);
    @(negedge clk);
    chk({tag, "_ready_idle"}, {31'b0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_write  = v.wr;
    req_size   = v.size;
    req_signed = v.sgn;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    wr0 = wr_cnt;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      #1;
      if (resp_valid) begin
        lat = i;
        break;
      end
    end
    chk({tag, "_latency"}, lat, v.exp_lat);
    chk({tag, "_rdata"}, resp_rdata, v.exp_rdata);
    chk({tag, "_error"}, {31'b0, resp_error}, {31'b0, v.exp_err});
    chk({tag, "_ready_resp"}, {31'b0, req_ready}, 32'd0);
    chk({tag, "_writes"}, wr_cnt - wr0, v.exp_wr);
    if (v.exp_wr != 0) chk({tag, "_mem_wdata"}, last_wd, v.exp_wdata);
    @(posedge clk);
    #1;
    chk({tag, "_pulse_end"}, {31'b0, resp_valid}, 32'd0);
  endtask

  initial begin
    //          wr    size   sgn   addr    wdata          rdata          err lat wr wdata
    vecs[0]  = '{1'b0, 2'b00, 1'b1, 32'h11, 32'h0,        32'hFFFFFFAA, 1'b0, 1, 0, 32'h0};
    vecs[1]  = '{1'b0, 2'b00, 1'b0, 32'h13, 32'h0,        32'h00000088, 1'b0, 1, 0, 32'h0};
    vecs[2]  = '{1'b0, 2'b01, 1'b1, 32'h12, 32'h0,        32'hFFFF8899, 1'b0, 1, 0, 32'h0};
    vecs[3]  = '{1'b0, 2'b01, 1'b1, 32'h10, 32'h0,        32'hFFFFAABB, 1'b0, 1, 0, 32'h0};
    vecs[4]  = '{1'b1, 2'b01, 1'b0, 32'h12, 32'h00001234, 32'h0,        1'b0, 2, 1, 32'h1234AABB};
    vecs[5]  = '{1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        32'h1234AABB, 1'b0, 1, 0, 32'h0};
    vecs[6]  = '{1'b1, 2'b10, 1'b0, 32'h20, 32'hDEADBEEF, 32'h0,        1'b0, 1, 1, 32'hDEADBEEF};
    vecs[7]  = '{1'b1, 2'b00, 1'b0, 32'h21, 32'h0000007F, 32'h0,        1'b0, 2, 1, 32'hDEAD7FEF};
    vecs[8]  = '{1'b0, 2'b11, 1'b0, 32'h20, 32'h0,        32'hDEAD7FEF, 1'b0, 1, 0, 32'h0};
    vecs[9]  = '{1'b0, 2'b00, 1'b0, 32'h23, 32'h0,        32'h000000DE, 1'b0, 1, 0, 32'h0};
`ifdef MISALIGN_TRAP_EN
    vecs[10] = '{1'b0, 2'b10, 1'b0, 32'h22, 32'h0,        32'h0,        1'b1, 1, 0, 32'h0};
    vecs[11] = '{1'b1, 2'b01, 1'b0, 32'h21, 32'h0000AAAA, 32'h0,        1'b1, 1, 0, 32'h0};
`else
    vecs[10] = '{1'b0, 2'b10, 1'b0, 32'h22, 32'h0,        32'hDEAD7FEF, 1'b0, 1, 0, 32'h0};
    vecs[11] = '{1'b1, 2'b01, 1'b0, 32'h21, 32'h0000AAAA, 32'h0,        1'b0, 2, 1, 32'hDEADAAAA};
`endif

    reset      = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_size   = 2'b00;
    req_signed = 1'b0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    preload    = 1'b1;
    pl_idx     = 6'd4;
    pl_data    = 32'h8899AABB;
    @(posedge clk);
    #1;
    pl_idx  = 6'd8;
    pl_data = 32'h0;
    @(posedge clk);
    #1;
    preload = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_mem_write", {31'b0, mem_write}, 32'd0);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_resp_error", {31'b0, resp_error}, 32'd0);
    chk("rst_mem_address", mem_address, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    reset = 1'b0;
    #1;
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);

    for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

    chk("mem_0x10", mem[4], 32'h1234AABB);

    // Reset in the WRITE cycle of a byte store: write suppressed, transaction dropped.
    begin
      int wr0;
      @(negedge clk);
      req_valid  = 1'b1;
      req_write  = 1'b1;
      req_size   = 2'b00;
      req_signed = 1'b0;
      req_addr   = 32'h10;
      req_wdata  = 32'h00000055;
      wr0 = wr_cnt;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("mid_rst_write_pending", {31'b0, mem_write}, 32'd1);
      reset = 1'b1;
      #1;
      chk("mid_rst_write_gated", {31'b0, mem_write}, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      chk("mid_rst_ready", {31'b0, req_ready}, 32'd1);
      for (int i = 0; i < 4; i++) begin
        chk("mid_rst_no_resp", {31'b0, resp_valid}, 32'd0);
        @(posedge clk);
        #1;
      end
      chk("mid_rst_mem", mem[4], 32'h1234AABB);
      chk("mid_rst_writes", wr_cnt - wr0, 32'd0);
      chk("mid_rst_rdata", resp_rdata, 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Data-side initiator for the MEM stage. It accepts one load or store per request from the pipeline and drives the word-addressed data memory: combinational read, write on the clock edge while `mem_write` is high. It handles byte, halfword and word accesses. Sub-word loads are extracted and sign- or zero-extended. Sub-word stores are done as read-modify-write. A one-cycle response pulse returns load data to writeback and releases the pipeline stall.

## Interface
Parameters:
- none; data and address width fixed at 32

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high
- req_valid  input  1  request present
- req_ready  output  1  unit idle, request accepted when req_valid && req_ready
- req_write  input  1  1 = store, 0 = load
- req_size  input  2  00 byte, 01 halfword, 10 word, 11 treated as word
- req_signed  input  1  sign-extend sub-word load
- req_addr  input  32  byte address
- req_wdata  input  32  store data, low-aligned (byte in [7:0], half in [15:0])
- resp_valid  output  1  one-cycle completion pulse
- resp_rdata  output  32  load result; 0 for stores
- resp_error  output  1  misaligned access, valid with resp_valid
- mem_write  output  1  memory write enable
- mem_address  output  32  word-aligned byte address, {addr[31:2],2'b00}
- mem_wdata  output  32  memory write data
- mem_rdata  input  32  memory combinational read data

## Operation
- Little-endian lanes: byte at addr[1:0]=n occupies bits [8n+7:8n]. Halfword at addr[1]=h occupies [16h+15:16h].
- States:
  - IDLE: req_ready=1. On accept, latch write, size, signed, addr and wdata, then go to ACCESS.
  - ACCESS:
    - mem_address comes from the latched address.
    - Load: extract the lane from mem_rdata, extend it, register it into resp_rdata, go to RESP.
    - Word store: mem_write=1, mem_wdata=latched wdata, go to RESP.
    - Sub-word store: capture mem_rdata into a merge buffer, go to WRITE.
  - WRITE: mem_write=1. mem_wdata = buffer with the target lane replaced by the low byte or half of wdata. Go to RESP.
  - RESP: resp_valid=1, req_ready=0, go to IDLE.
- req_ready is high only in IDLE. req_* inputs are ignored in all other states.
- mem_write is high only in ACCESS (word store) or WRITE. It is forced to 0 whenever reset is high.
- mem_address holds the latched address in every state.
- In IDLE, mem_wdata = 0.
- resp_rdata holds its value until the next load completes. A store clears it to 0 in RESP.

## Timing
- Request accepted at edge T (state becomes ACCESS).
- Load and word store: resp_valid high in the cycle after edge T+1.
- Sub-word store: resp_valid high in the cycle after edge T+2.
- Next accept is possible no earlier than the cycle after resp_valid.
- The memory write lands on the edge that closes the ACCESS or WRITE cycle. A load issued right after a store sees the new data.
- Reset values: state IDLE, req_ready=1 after reset deasserts, resp_valid=0, resp_rdata=0, resp_error=0, mem_write=0, mem_address=0, mem_wdata=0, latches and buffer=0.
- Reset mid-operation: the transaction is dropped, no write is issued and no response is produced.

## Configuration
- MISALIGN_TRAP_EN defined:
  - A halfword with addr[0]=1, or a word with addr[1:0]≠0, skips memory access entirely: ACCESS goes straight to RESP with mem_write=0, resp_error=1 and resp_rdata=0.
  - Latency is the same as a load.
- Not defined:
  - resp_error is constant 0.
  - Halfword ignores addr[0]; word ignores addr[1:0]. The access uses the aligned-down lane.

## Test plan
- Memory[0x10]=0x8899AABB; signed byte load at 0x11 -> resp_rdata=0xFFFFFFAA, resp_valid at T+2.
- Same word; unsigned byte load at 0x13 -> 0x00000088. Signed halfword load at 0x12 -> 0xFFFF8899.
- Halfword store 0x00001234 at 0x12 -> exactly one mem_write pulse, in WRITE, with mem_wdata=0x1234AABB. resp_valid at T+3. A follow-up word load at 0x10 returns 0x1234AABB.
- Word store 0xDEADBEEF at 0x20 -> mem_write high for a single cycle (ACCESS), resp_rdata=0, resp_valid at T+2. Byte store 0x7F at 0x21 afterwards -> word becomes 0xDEAD7FEF.
- Word load at 0x22 with 0x20=0xDEADBEEF:
  - With MISALIGN_TRAP_EN: resp_error=1, resp_rdata=0, no mem_write.
  - Without it: resp_rdata=0xDEADBEEF, resp_error=0.
- Reset asserted during WRITE of a byte store -> mem_write=0 that cycle, memory unchanged, no resp_valid, req_ready=1 the cycle after reset drops.
